// File: rtl/mult_hilo.sv
// HI/LO control stage behind the combinational 32x32 multiplier: latches operands,
// waits LAT cycles for the product to settle, then commits MULT/MULTU/MADD/MSUB into HI/LO.
module mult_hilo #(
    parameter int unsigned LAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_z,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MTHI  = 3'b010;
    localparam logic [2:0] OP_MTLO  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b101;

    // LAT is legal in 1..15, so LAT-1 always fits the 4-bit settle counter.
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Turns the signed product's upper word into the unsigned one for the latched operands.
    function automatic logic [31:0] multu_hi_fix(
        input logic [31:0] p_hi,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] add_a;
        logic [31:0] add_b;
        add_a = a[31] ? b : 32'd0;
        add_b = b[31] ? a : 32'd0;
        return p_hi + add_a + add_b;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  counter_q, counter_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] mul_a_q, mul_a_d;
    logic [31:0] mul_b_q, mul_b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [63:0] acc_s;

    assign acc_s = {hi_q, lo_q};

    // Next-state logic: accept / MTHI-MTLO in IDLE, settle countdown, commit or abort in BUSY.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        op_d      = op_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                            mul_a_d   = rs_val;
                            mul_b_d   = rt_val;
                            op_d      = op;
                            counter_d = CNT_INIT;
                            busy_d    = 1'b1;
                            state_d   = ST_BUSY;
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (counter_q == 4'd0) begin
                    case (op_q)
                        OP_MULT:  {hi_d, lo_d} = mul_z;
                        OP_MULTU: begin
                            hi_d = multu_hi_fix(mul_z[63:32], mul_a_q, mul_b_q);
                            lo_d = mul_z[31:0];
                        end
                        OP_MADD:  {hi_d, lo_d} = acc_s + mul_z;
                        OP_MSUB:  {hi_d, lo_d} = acc_s - mul_z;
                        default: begin
                            hi_d = hi_q;
                            lo_d = lo_q;
                        end
                    endcase
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    counter_d = counter_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and architectural registers; reset mid-op discards everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            counter_q <= 4'd0;
            op_q      <= 3'd0;
            mul_a_q   <= 32'd0;
            mul_b_q   <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            op_q      <= op_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign mul_a = mul_a_q;
    assign mul_b = mul_b_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_mult_hilo.sv
// Directed bench for mult_hilo (LAT=3) with a behavioural multiplier driving mul_z.
module tb_mult_hilo;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_z;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int total;
    int bad;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MTHI  = 3'b010;
    localparam logic [2:0] OP_MTLO  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b101;
    localparam logic [2:0] OP_RSVD  = 3'b110;

    mult_hilo #(.LAT(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .flush  (flush),
        .mul_a  (mul_a),
        .mul_b  (mul_b),
        .mul_z  (mul_z),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done)
    );

    // Signed 32x32 product: sign-extend both operands, low 64 bits of the product.
    assign mul_z = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        tick();
        start  = 1'b0;
    endtask

    // Multiply op with LAT=3: busy for three cycles, then a done pulse with the result.
    task automatic run_mul(input string tag, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
        issue(o, a, b);
        for (int i = 0; i < 3; i++) begin
            check({tag, "_busy"}, {63'd0, busy}, 64'd1);
            check({tag, "_nodone"}, {63'd0, done}, 64'd0);
            tick();
        end
        check({tag, "_busy_off"}, {63'd0, busy}, 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_hilo"}, {hi, lo}, {exp_hi, exp_lo});
        tick();
        check({tag, "_done_off"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 3'd0;
        rs_val = 32'd0;
        rt_val = 32'd0;
        flush  = 1'b0;
        #12;
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_mul", {mul_a, mul_b}, 64'd0);
        check("rst_flags", {62'd0, busy, done}, 64'd0);
        rst_n = 1'b1;
        tick();

        run_mul("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        check("mul_ops_held", {mul_a, mul_b}, {32'hFFFF_FFFE, 32'h0000_0003});
        run_mul("multu_ff", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_mul("multu_msb", OP_MULTU, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000);

        issue(OP_MTHI, 32'h1234_5678, 32'd0);
        check("mthi", {hi, lo}, {32'h1234_5678, 32'h0000_0000});
        check("mthi_flags", {62'd0, busy, done}, 64'd0);
        issue(OP_MTLO, 32'h0000_0000, 32'd0);
        check("mtlo", {hi, lo}, {32'h1234_5678, 32'h0000_0000});
        run_mul("madd", OP_MADD, 32'd2, 32'd3, 32'h1234_5678, 32'h0000_0006);
        run_mul("msub", OP_MSUB, 32'd2, 32'd3, 32'h1234_5678, 32'h0000_0000);

        issue(OP_MTHI, 32'hFFFF_FFFF, 32'd0);
        issue(OP_MTLO, 32'hFFFF_FFFF, 32'd0);
        check("mt_ones", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
        run_mul("madd_wrap", OP_MADD, 32'd1, 32'd1, 32'h0000_0000, 32'h0000_0000);
        run_mul("msub_wrap", OP_MSUB, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Requests while busy are dropped; only the first op commits.
        issue(OP_MULT, 32'd5, 32'd7);
        start = 1'b1; op = OP_MULTU; rs_val = 32'd9; rt_val = 32'd9;
        tick();
        check("ign_busy", {63'd0, busy}, 64'd1);
        op = OP_MTLO; rs_val = 32'h0000_DEAD;
        tick();
        start = 1'b0;
        check("ign_lo", {32'd0, lo}, 64'hFFFF_FFFF);
        tick();
        check("ign_done", {63'd0, done}, 64'd1);
        check("ign_hilo", {hi, lo}, {32'h0, 32'd35});
        check("ign_ops", {mul_a, mul_b}, {32'd5, 32'd7});
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ign_one_done", {62'd0, busy, done}, 64'd0);
        end

        // Flush during the second busy cycle aborts with HI/LO untouched.
        issue(OP_MULT, 32'h0000_0100, 32'h0000_0100);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", {62'd0, busy, done}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("flush_nodone", {62'd0, busy, done}, 64'd0);
        end
        check("flush_hilo", {hi, lo}, {32'h0, 32'd35});

        // Flush beats start in IDLE; reserved op is a no-op.
        flush = 1'b1;
        issue(OP_MTHI, 32'h0000_BEEF, 32'd0);
        check("flush_mthi", {hi, lo}, {32'h0, 32'd35});
        issue(OP_MULT, 32'd4, 32'd4);
        flush = 1'b0;
        check("flush_mult", {62'd0, busy, done}, 64'd0);
        issue(OP_RSVD, 32'h1111_1111, 32'h2222_2222);
        check("rsvd_flags", {62'd0, busy, done}, 64'd0);
        check("rsvd_hilo", {hi, lo}, {32'h0, 32'd35});

        // Back-to-back: a new op accepted in the done cycle.
        issue(OP_MULT, 32'd3, 32'd4);
        tick(); tick(); tick();
        check("b2b_first", {hi, lo}, 64'd12);
        run_mul("b2b_second", OP_MULT, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        // Asynchronous reset in the middle of an op.
        issue(OP_MULT, 32'd10, 32'd10);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_hilo", {hi, lo}, 64'd0);
        check("arst_mul", {mul_a, mul_b}, 64'd0);
        check("arst_flags", {62'd0, busy, done}, 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("arst_idle", {62'd0, busy, done}, 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_hilo.md
Name: mult_hilo

Overview:
- HI/LO control stage sitting directly downstream of the combinational 32x32 signed (Baugh-Wooley) multiplier in the MIPS datapath.
- Latches operands from the ID/EX stage and drives them to the multiplier.
- Waits a fixed multi-cycle settle latency, then captures the 64-bit product, applies the unsigned correction or accumulate, and updates the architectural HI/LO registers.
- Asserts busy so the pipeline stalls MFHI/MFLO and further multiply-unit ops.

Parameters:
- LAT, 3: cycles the multiplier product is allowed to settle before capture; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  op request, single-cycle qualifier.
- op  in  3  000 MULT, 001 MULTU, 010 MTHI, 011 MTLO, 100 MADD, 101 MSUB, 11x reserved (no-op).
- rs_val  in  32  operand A / MTHI-MTLO data.
- rt_val  in  32  operand B.
- flush  in  1  cancels an in-flight op (exception/branch squash).
- mul_a  out  32  registered operand to the multiplier.
- mul_b  out  32  registered operand to the multiplier.
- mul_z  in  64  signed product from the multiplier.
- hi  out  32  HI register.
- lo  out  32  LO register.
- busy  out  1  high while a multiply op is in flight.
- done  out  1  one-cycle pulse; new HI/LO visible in this cycle.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low (rst_n).
- Reset values: hi=0, lo=0, mul_a=0, mul_b=0, busy=0, done=0, state=IDLE, counter=0. Reset mid-op aborts the op and HI/LO return to 0.
- States:
  - IDLE -> BUSY on start with op in {MULT, MULTU, MADD, MSUB} and flush=0.
  - BUSY -> IDLE when counter==0 (commit), or on flush (abort).
- Accept (IDLE, start, multiply op), at the edge:
  - mul_a<=rs_val, mul_b<=rt_val.
  - Latch op into op_q.
  - counter<=LAT-1, busy<=1.
- BUSY: counter decrements each cycle. In the cycle counter==0, the next edge performs the commit:
  - Let P = mul_z (signed product).
  - MULTU: P_hi += (mul_a[31] ? mul_b : 0) + (mul_b[31] ? mul_a : 0), mod 2^32; P_lo unchanged.
  - MULT and MULTU: {hi,lo}<=P.
  - MADD: {hi,lo}<={hi,lo}+P, mod 2^64.
  - MSUB: {hi,lo}<={hi,lo}-P, mod 2^64.
  - MADD/MSUB operands are signed.
  - After the commit: busy<=0, done<=1 for exactly one cycle, state<=IDLE.
- Timing: start accepted at edge k gives busy high for cycles k..k+LAT-1, HI/LO updated at edge k+LAT, and done high for the cycle following that edge.
- MTHI/MTLO (IDLE, start): hi or lo <= rs_val at the next edge. busy stays 0, done stays 0, the other register is unchanged.
- start while BUSY: ignored entirely (upstream must hold on busy), including MTHI/MTLO.
- flush:
  - In BUSY: state<=IDLE, busy<=0, HI/LO unchanged, no done.
  - In IDLE with start: flush wins and the op is dropped, including MTHI/MTLO.
- done and a new accept: done may coincide with a new start accept in the IDLE cycle after a commit; back-to-back ops are therefore legal.
- Reserved op: accepted as a no-op with no state change.
- Outputs: hi and lo are direct register outputs, so MFHI/MFLO reads are combinational from them. mul_a and mul_b hold their values until the next accept.

Test Plan:
- MULT, LAT=3, rs=0xFFFFFFFE, rt=0x00000003 -> busy high 3 cycles, then done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU rs=rt=0xFFFFFFFF (signed product 1) -> hi=0xFFFFFFFE, lo=0x00000001. MULTU rs=0x80000000, rt=2 -> hi=0x00000001, lo=0x00000000.
- MTHI 0x12345678, then MTLO 0x0, then MADD 2*3 -> hi=0x12345678, lo=0x00000006. Then MSUB 2*3 -> hi=0x12345678, lo=0x00000000.
- MTHI/MTLO 0xFFFFFFFF, then MADD 1*1 -> wrap to hi=0, lo=0. MSUB 1*1 from 0 -> hi=lo=0xFFFFFFFF.
- start MULTU and MTLO 0xDEAD issued while busy -> both ignored; first op's result committed unchanged; exactly one done.
- flush in second BUSY cycle -> busy drops next edge, HI/LO keep prior values, no done. rst_n low mid-op -> all outputs 0 immediately (asynchronous).
